// File: rtl/bitrev_spi_ctrl.sv
// SPI mode-0 master that sends one request byte and reads one reply byte per frame.
// A frame is TX bits, RX bits, a select hold and an idle gap, then a single response strobe.
`timescale 1ns/1ps
module bitrev_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int TX_BITS = 8,
  parameter int RX_BITS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_data,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       busy,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);

  localparam int MAX_BITS = (TX_BITS > RX_BITS) ? TX_BITS : RX_BITS;
  localparam int BW       = $clog2(MAX_BITS + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    TX   = 3'd1,
    RX   = 3'd2,
    HOLD = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t          state_r;
  logic [7:0]      div_cnt_r;
  logic [BW-1:0]   bit_cnt_r;
  logic [7:0]      tx_shift_r;
  logic [7:0]      rx_shift_r;
  logic            div_tc_s;

  assign div_tc_s = (div_cnt_r == 8'(CLK_DIV - 1));

  // Frame sequencer: owns the FSM, the sck half-period timer and every registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      div_cnt_r  <= 8'd0;
      bit_cnt_r  <= '0;
      tx_shift_r <= 8'h00;
      rx_shift_r <= 8'h00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= 8'h00;
      busy       <= 1'b0;
      sck        <= 1'b0;
      ss         <= 1'b1;
      mosi       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          div_cnt_r <= 8'd0;
          bit_cnt_r <= '0;
          sck       <= 1'b0;
          if (req_valid && req_ready) begin
            state_r    <= TX;
            tx_shift_r <= req_data;
            rx_shift_r <= 8'h00;
            mosi       <= req_data[7];
            ss         <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
          end else begin
            ss        <= 1'b1;
            mosi      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        TX, RX: begin
          if (div_tc_s) begin
            div_cnt_r <= 8'd0;
            sck       <= ~sck;
            // The falling edge closes a bit: advance mosi in TX, capture miso in RX.
            if (sck) begin
              if (state_r == TX) begin
                tx_shift_r <= {tx_shift_r[6:0], tx_shift_r[7]};
                if (bit_cnt_r == BW'(TX_BITS - 1)) begin
                  state_r   <= RX;
                  bit_cnt_r <= '0;
                  mosi      <= 1'b0;
                end else begin
                  bit_cnt_r <= bit_cnt_r + BW'(1);
                  mosi      <= tx_shift_r[6];
                end
              end else begin
                rx_shift_r <= {rx_shift_r[6:0], miso};
                if (bit_cnt_r == BW'(RX_BITS - 1)) begin
                  state_r   <= HOLD;
                  bit_cnt_r <= '0;
                end else begin
                  bit_cnt_r <= bit_cnt_r + BW'(1);
                end
              end
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        HOLD: begin
          if (div_tc_s) begin
            div_cnt_r <= 8'd0;
            state_r   <= GAP;
            ss        <= 1'b1;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        GAP: begin
          // Leaving GAP presents the result and reopens the request port in the same cycle.
          if (div_tc_s) begin
            div_cnt_r  <= 8'd0;
            state_r    <= IDLE;
            resp_valid <= 1'b1;
            resp_data  <= rx_shift_r;
            req_ready  <= 1'b1;
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r   <= IDLE;
          div_cnt_r <= 8'd0;
          bit_cnt_r <= '0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          sck       <= 1'b0;
          ss        <= 1'b1;
          mosi      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitrev_spi_ctrl.sv
// Bench for bitrev_spi_ctrl: two instances (CLK_DIV=4 and CLK_DIV=1), each with a
// bit-reversal peripheral model, a response scoreboard and a frame-shape monitor.
`timescale 1ns/1ps
module tb_bitrev_spi_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid [2];
  logic [7:0] req_data  [2];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int CD = (g == 0) ? 4 : 1;
    logic       ready_w, resp_valid_w, busy_w, sck_w, ss_w, mosi_w;
    logic       miso_w = 1'b0;
    logic [7:0] resp_data_w;

    bitrev_spi_ctrl #(.CLK_DIV(CD), .TX_BITS(8), .RX_BITS(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid[g]),
      .req_ready  (ready_w),
      .req_data   (req_data[g]),
      .resp_valid (resp_valid_w),
      .resp_data  (resp_data_w),
      .busy       (busy_w),
      .sck        (sck_w),
      .ss         (ss_w),
      .mosi       (mosi_w),
      .miso       (miso_w)
    );

    // Peripheral: captures 8 bits on sck rises, then returns them LSB first; ss high clears it.
    int         pcnt = 0;
    logic [7:0] pshift = 8'h00;
    always @(posedge sck_w or posedge ss_w) begin
      if (ss_w) begin
        pcnt   = 0;
        miso_w = 1'b0;
      end else begin
        if (pcnt < 8) pshift = {pshift[6:0], mosi_w};
        else if (pcnt < 16) miso_w = pshift[pcnt-8];
        pcnt++;
      end
    end

    int         acc_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] txq   [$];
    bit         skip_frame = 1'b0;
    bit         seen_frame = 1'b0;
    logic       ss_p = 1'b1, sck_p = 1'b0;
    int         lowc = 0, rises = 0, hi_cnt = 0;
    logic [7:0] mbits = 8'h00;

    // Scoreboard and frame monitor, sampled on the falling clock edge.
    always @(negedge clock) begin
      int a;
      logic [7:0] e;
      if (req_valid[g] && ready_w) acc_q.push_back(cyc + 1);
      if (resp_valid_w) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp lane%0d: got resp 0x%0h, required no response", g, resp_data_w);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check($sformatf("resp_data lane%0d", g), resp_data_w, e);
          check($sformatf("latency lane%0d", g), cyc - a, 34 * CD);
        end
      end
      if (ss_p && !ss_w) begin
        if (seen_frame) check($sformatf("ss_gap_ok lane%0d", g), int'(hi_cnt >= CD), 1);
        lowc  = 0;
        rises = 0;
      end
      if (!ss_w) begin
        lowc++;
        if (sck_w && !sck_p) begin
          if (rises < 8) mbits = {mbits[6:0], mosi_w};
          rises++;
        end
      end else begin
        hi_cnt++;
      end
      if (!ss_p && ss_w) begin
        hi_cnt     = 1;
        seen_frame = 1'b1;
        if (skip_frame) begin
          skip_frame = 1'b0;
        end else if (txq.size() != 0) begin
          e = txq.pop_front();
          check($sformatf("sck_rises lane%0d", g), rises, 16);
          check($sformatf("ss_low_cycles lane%0d", g), lowc, 33 * CD);
          check($sformatf("mosi_bits lane%0d", g), mbits, e);
        end
      end
      ss_p  = ss_w;
      sck_p = sck_w;
    end
  end

  function automatic logic rdy(input int l);
    if (l == 0) return lane[0].ready_w;
    else return lane[1].ready_w;
  endfunction

  function automatic logic rvld(input int l);
    if (l == 0) return lane[0].resp_valid_w;
    else return lane[1].resp_valid_w;
  endfunction

  function automatic bit pending(input int l);
    if (l == 0) return lane[0].busy_w || (lane[0].exp_q.size() != 0);
    else return lane[1].busy_w || (lane[1].exp_q.size() != 0);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int l, input logic [7:0] d, input logic [7:0] e,
                      input bit has_exp, input bit keep, output bit rv_acc);
    int n;
    n = 0;
    req_valid[l] = 1'b1;
    req_data[l]  = d;
    if (has_exp) begin
      if (l == 0) begin
        lane[0].exp_q.push_back(e);
        lane[0].txq.push_back(d);
      end else begin
        lane[1].exp_q.push_back(e);
        lane[1].txq.push_back(d);
      end
    end
    while (!rdy(l) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout lane%0d: waited %0d cycles, required < 300", l, n);
    end
    rv_acc = rvld(l);
    tick();
    if (!keep) req_valid[l] = 1'b0;
  endtask

  task automatic wait_done(input int l);
    int n;
    n = 0;
    while (pending(l) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL done_timeout lane%0d: still busy after %0d cycles, required idle", l, n);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit rv;
    logic [7:0] vec [4][2];
    vec[0] = '{8'hB1, 8'h8D};
    vec[1] = '{8'h01, 8'h80};
    vec[2] = '{8'hF0, 8'h0F};
    vec[3] = '{8'hFF, 8'hFF};
    req_valid = '{1'b0, 1'b0};
    req_data  = '{8'h00, 8'h00};
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();

    // Reset held for three cycles while idle
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_ss", lane[0].ss_w, 1);
    check("rst_sck", lane[0].sck_w, 0);
    check("rst_mosi", lane[0].mosi_w, 0);
    check("rst_resp_valid", lane[0].resp_valid_w, 0);
    check("rst_resp_data", lane[0].resp_data_w, 8'h00);
    check("rst_req_ready", lane[0].ready_w, 1);
    check("rst_busy", lane[0].busy_w, 0);
    tick();

    for (int i = 0; i < 4; i++) begin
      send(0, vec[i][0], vec[i][1], 1'b1, 1'b0, rv);
      wait_done(0);
      repeat (3) tick();
    end

    // Back-to-back with req_valid held
    send(0, 8'h12, 8'h48, 1'b1, 1'b1, rv);
    send(0, 8'h34, 8'h2C, 1'b1, 1'b0, rv);
    check("b2b_accept_in_resp_cycle", rv, 1);
    wait_done(0);
    repeat (3) tick();

    // Request lines toggled while busy must be ignored
    send(0, 8'h6B, 8'hD6, 1'b1, 1'b0, rv);
    for (int i = 0; i < 120; i++) begin
      req_valid[0] = 1'($urandom_range(0, 1));
      req_data[0]  = 8'($urandom);
      check("busy_req_ready", lane[0].ready_w, 0);
      tick();
    end
    req_valid[0] = 1'b0;
    wait_done(0);
    repeat (3) tick();

    // Reset mid-frame discards the transaction
    lane[0].skip_frame = 1'b1;
    send(0, 8'h5A, 8'h00, 1'b0, 1'b0, rv);
    repeat (48) tick();
    reset = 1'b1;
    tick();
    check("abort_ss", lane[0].ss_w, 1);
    check("abort_sck", lane[0].sck_w, 0);
    check("abort_resp_valid", lane[0].resp_valid_w, 0);
    reset = 1'b0;
    lane[0].acc_q.delete();
    lane[1].acc_q.delete();
    repeat (10) tick();
    send(0, 8'h0F, 8'hF0, 1'b1, 1'b0, rv);
    wait_done(0);
    repeat (3) tick();

    // Fastest divider
    send(1, 8'hB1, 8'h8D, 1'b1, 1'b0, rv);
    wait_done(1);
    send(1, 8'h01, 8'h80, 1'b1, 1'b0, rv);
    wait_done(1);
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitrev_spi_ctrl.md
Name: bitrev_spi_ctrl

Overview:
- SPI master and transaction sequencer for the SPI bit-reversal peripheral.
- Accepts one byte from a valid/ready requester and frames the whole exchange: asserts ss (active low), clocks 8 sck pulses out on mosi, then 8 more pulses to read the result back on miso.
- Deasserts ss, observes a minimum idle gap, then returns the received byte with a one-cycle response strobe.
- Sits between the bus-side requester and the peripheral's sck/ss/mosi/miso pins; it is the only master on that link.

Parameters:
- CLK_DIV, 4, clock cycles per sck half-period; legal range 1..255.
- TX_BITS, 8, bits shifted out per transaction.
- RX_BITS, 8, bits shifted in per transaction.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request; high only in IDLE.
- req_data  input  8  byte to send.
- resp_valid  output  1  one-cycle strobe: resp_data is new.
- resp_data  output  8  received byte; held until the next accepted request.
- busy  output  1  high from accept until resp_valid, inclusive.
- sck  output  1  SPI clock; idles low; registered.
- ss  output  1  slave select, active low; idles high; registered.
- mosi  output  1  master data out, MSB first; registered.
- miso  input  1  slave data in.

Behaviour:
- Reset values: req_ready=1 after reset releases; resp_valid=0, resp_data=0, busy=0, sck=0, ss=1, mosi=0; FSM=IDLE; half-period counter=0.
- Reset mid-transaction: on the next cycle ss=1 and sck=0, with no resp_valid. The peripheral clears itself on ss high. The partial result is discarded.
- Accept: req_valid&&req_ready at edge E. req_data is latched into tx_shift. req_data is ignored while req_ready=0.
- FSM states: IDLE -> TX -> RX -> HOLD -> GAP -> IDLE.
- SPI mode 0 (CPOL=0, CPHA=0). Each bit is a low half followed by a high half, each CLK_DIV cycles long.
- Half-period counter counts 0..CLK_DIV-1. Every terminal count toggles sck; after two toggles, the bit counter increments.
- TX state:
  - From cycle E+1: ss=0, sck=0, mosi=tx_shift[7].
  - The slave samples mosi on each sck rise.
  - mosi advances to the next bit (tx_shift shifts left) in the same cycle sck falls.
  - After TX_BITS falling edges, go to RX.
- RX state:
  - mosi=0; same sck waveform for RX_BITS pulses.
  - The slave drives miso after each rise.
  - The master samples miso in the cycle sck falls: rx_shift={rx_shift[6:0],miso}.
  - After RX_BITS falling edges, go to HOLD.
- HOLD: ss=0, sck=0 for CLK_DIV cycles, then ss=1.
- GAP: ss=1, sck=0 for CLK_DIV cycles, guaranteeing a peripheral reset between frames.
- GAP exit cycle:
  - resp_data<=rx_shift and resp_valid=1 for exactly 1 cycle.
  - FSM=IDLE, so req_ready=1 in that same cycle.
  - A new request may be accepted in that cycle (back-to-back). ss stays high for at least CLK_DIV cycles between frames.
- Latency: accept at E gives resp_valid visible at cycle E+34*CLK_DIV+1 (TX_BITS=RX_BITS=8). ss is low for exactly 33*CLK_DIV cycles; there are exactly 16 sck rising edges per frame.
- With the bit-reversal peripheral: resp_data = bit-reverse(req_data).
- resp_valid has no backpressure; a consumer that is not ready loses only the strobe, not resp_data.
- CLK_DIV=1: sck toggles every cycle and all rules above hold unchanged.
- Counters are sized for their maximum values, with no wrap inside a frame. The bit counter wraps to 0 on each TX->RX and RX->HOLD transition.

Test Plan:
- Reset: hold reset 3 cycles mid-idle -> ss=1, sck=0, mosi=0, resp_valid=0, resp_data=0x00, req_ready=1.
- Basic, CLK_DIV=4, bitrev peripheral model: req 0xB1 -> resp_data=0x8D, resp_valid at accept+137. Check 16 sck rises, ss low exactly 132 cycles, mosi bits 1,0,1,1,0,0,0,1 at the first 8 rises.
- Bit ordering: req 0x01 -> 0x80; req 0xF0 -> 0x0F; req 0xFF -> 0xFF.
- Back-to-back, req_valid held with 0x12 then 0x34: second accepted in the resp_valid cycle of the first. Responses are 0x48 then 0x2C; ss high ≥4 cycles between frames.
- Busy handling: toggle req_valid/req_data randomly while busy -> req_ready=0 throughout, no extra accept, result unaffected.
- Reset mid-frame at accept+50 -> next cycle ss=1, sck=0, no resp_valid. Then req 0x0F -> 0xF0 correct.
- CLK_DIV=1: req 0xB1 -> 0x8D at accept+35.
